// File: rtl/draw_pkg.sv
// draw_pkg: constants and types shared by the rectangle drawing engine and
// the game datapath that issues its commands (screen size, default
// coordinate/colour widths, the 3-bit VGA palette, engine state encoding).
package draw_pkg;

  // Visible raster of the VGA adapter.
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  // Default widths for x / width, y / height and colour.
  localparam int X_W_DEF = 8;
  localparam int Y_W_DEF = 7;
  localparam int C_W_DEF = 3;

  // 3-bit RGB palette.
  localparam logic [2:0] BLACK   = 3'b000;
  localparam logic [2:0] BLUE    = 3'b001;
  localparam logic [2:0] GREEN   = 3'b010;
  localparam logic [2:0] CYAN    = 3'b011;
  localparam logic [2:0] RED     = 3'b100;
  localparam logic [2:0] MAGENTA = 3'b101;
  localparam logic [2:0] YELLOW  = 3'b110;
  localparam logic [2:0] WHITE   = 3'b111;

  // Engine state encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/raster_counter.sv
// raster_counter: column/row counter pair that walks a w x h rectangle in
// raster order (column fastest). col/row/last/is_edge describe the pixel
// being issued this cycle; the parent registers it into its output stage,
// and the counters store it as the position the next step advances from.
module raster_counter
  import draw_pkg::*;
#(
  parameter int X_W = X_W_DEF,
  parameter int Y_W = Y_W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           step,
  input  logic [X_W-1:0] w,
  input  logic [Y_W-1:0] h,
  output logic [X_W-1:0] col,
  output logic [Y_W-1:0] row,
  output logic           last,
  output logic           is_edge
);

  logic [X_W-1:0] col_q;
  logic [Y_W-1:0] row_q;
  logic [X_W-1:0] w_m1;
  logic [Y_W-1:0] h_m1;

  assign w_m1 = w - 1'b1;
  assign h_m1 = h - 1'b1;

  // Pick the pixel issued this cycle: origin on start, raster successor on step.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the if/else leaves it unassigned and infers a latch.
    col = col_q;
    row = row_q;
    if (start) begin
      col = '0;
      row = '0;
    end else if (step) begin
      if (col_q == w_m1) begin
        col = '0;
        row = row_q + 1'b1;
      end else begin
        col = col_q + 1'b1;
      end
    end
  end

  assign last    = (col == w_m1) && (row == h_m1);
  assign is_edge = (col == '0) || (col == w_m1) || (row == '0) || (row == h_m1);

  // Remember the issued pixel so the next step continues from it.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples values from before the edge, independent of statement order.
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col;
      row_q <= row;
    end
  end

endmodule

// File: rtl/rect_plotter.sv
// rect_plotter: accepts one rectangle command per valid/ready handshake and
// streams it to the 160x120 VGA adapter as one pixel write per clock, either
// solid or border-only. Adapter-facing outputs are registered; the pixel for
// the next cycle is computed from the command fields (on accept) or from the
// latched fields (while drawing).
// Optional build macro RECT_PLOTTER_CLIP_EN: suppress plot for pixels that
// fall off-screen or whose coordinate addition overflowed.
module rect_plotter
  import draw_pkg::*;
#(
  parameter int X_W = X_W_DEF,
  parameter int Y_W = Y_W_DEF,
  parameter int C_W = C_W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [X_W-1:0] cmd_x,
  input  logic [Y_W-1:0] cmd_y,
  input  logic [X_W-1:0] cmd_w,
  input  logic [Y_W-1:0] cmd_h,
  input  logic [C_W-1:0] cmd_colour,
  input  logic           cmd_outline,
  output logic [X_W-1:0] xout,
  output logic [Y_W-1:0] yout,
  output logic [C_W-1:0] colourout,
  output logic           plot,
  output logic           busy,
  output logic           done
);

  state_t         state_q, state_d;

  // Command fields latched on accept.
  logic [X_W-1:0] x_q, w_q;
  logic [Y_W-1:0] y_q, h_q;
  logic [C_W-1:0] colour_q;
  logic           outline_q;
  // The pixel currently on the outputs is the last of the rectangle.
  logic           last_q;

  logic           accept, empty_cmd, start, step, issue;
  logic [X_W-1:0] x_eff, w_eff;
  logic [Y_W-1:0] y_eff, h_eff;
  logic [C_W-1:0] colour_eff;
  logic           outline_eff;

  logic [X_W-1:0] col;
  logic [Y_W-1:0] row;
  logic           pix_last, pix_edge;

  logic [X_W-1:0] x_sum;
  logic [Y_W-1:0] y_sum;
  logic           clip_ok;
  logic           pix_on;

  assign accept    = (state_q == IDLE) && cmd_valid;
  assign empty_cmd = (cmd_w == '0) || (cmd_h == '0);
  assign start     = accept && !empty_cmd;
  assign step      = (state_q == DRAW) && !last_q;
  assign issue     = start || step;

  // On the accept cycle the first pixel comes straight from the command.
  assign x_eff       = start ? cmd_x       : x_q;
  assign y_eff       = start ? cmd_y       : y_q;
  assign w_eff       = start ? cmd_w       : w_q;
  assign h_eff       = start ? cmd_h       : h_q;
  assign colour_eff  = start ? cmd_colour  : colour_q;
  assign outline_eff = start ? cmd_outline : outline_q;

  raster_counter #(
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_raster (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .step    (step),
    .w       (w_eff),
    .h       (h_eff),
    .col     (col),
    .row     (row),
    .last    (pix_last),
    .is_edge (pix_edge)
  );

`ifdef RECT_PLOTTER_CLIP_EN
  // One extra bit catches wrap-around of the coordinate addition.
  logic [X_W:0] x_wide;
  logic [Y_W:0] y_wide;

  assign x_wide  = {1'b0, x_eff} + {1'b0, col};
  assign y_wide  = {1'b0, y_eff} + {1'b0, row};
  assign x_sum   = x_wide[X_W-1:0];
  assign y_sum   = y_wide[Y_W-1:0];
  assign clip_ok = !x_wide[X_W] && !y_wide[Y_W] &&
                   (x_sum < X_W'(SCREEN_W)) && (y_sum < Y_W'(SCREEN_H));
`else
  // Coordinates wrap modulo the port widths; nothing is suppressed.
  assign x_sum   = x_eff + col;
  assign y_sum   = y_eff + row;
  assign clip_ok = 1'b1;
`endif

  assign pix_on = (!outline_eff || pix_edge) && clip_ok;

  // Next-state logic: IDLE -> DRAW (or DONE when empty) -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = empty_cmd ? DONE : DRAW;
      DRAW:    if (last_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Latch command fields and register the pixel issued this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q       <= '0;
      y_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      colour_q  <= '0;
      outline_q <= 1'b0;
      last_q    <= 1'b0;
      xout      <= '0;
      yout      <= '0;
      colourout <= '0;
      plot      <= 1'b0;
    end else begin
      if (accept) begin
        x_q       <= cmd_x;
        y_q       <= cmd_y;
        w_q       <= cmd_w;
        h_q       <= cmd_h;
        colour_q  <= cmd_colour;
        outline_q <= cmd_outline;
      end
      if (issue) last_q <= pix_last;
      xout      <= issue ? x_sum      : '0;
      yout      <= issue ? y_sum      : '0;
      colourout <= issue ? colour_eff : '0;
      plot      <= issue && pix_on;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: doc/rect_plotter.md
# rect_plotter

Rectangle drawing engine that accepts one draw command per handshake from the game datapath and turns it into a raster stream of pixel writes for the 160x120, 3-bit-colour VGA adapter. It drives the adapter's x/y/colour/plot inputs one pixel per clock. It is the producer side of the plot interface, so the game datapath only issues rectangle commands: blocks, start block, target, clear-screen.

## Interface
Parameters:
- X_W, 8, x coordinate / width bits
- Y_W, 7, y coordinate / height bits
- C_W, 3, colour bits

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock (CLOCK_50)
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command this cycle
- cmd_x  in  X_W  left column
- cmd_y  in  Y_W  top row
- cmd_w  in  X_W  width in pixels (0 = empty)
- cmd_h  in  Y_W  height in pixels (0 = empty)
- cmd_colour  in  C_W  fill colour
- cmd_outline  in  1  1 = border pixels only, 0 = solid fill
- xout  out  X_W  pixel x to adapter
- yout  out  Y_W  pixel y to adapter
- colourout  out  C_W  pixel colour to adapter
- plot  out  1  write strobe to adapter
- busy  out  1  command in progress
- done  out  1  one-cycle pulse when a command completes

## Operation
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch all cmd_* fields, reset the column and row counters to 0, and go to DRAW.
    - If w==0 or h==0, go straight to DONE instead.
  - DRAW: each cycle present pixel (cmd_x+col, cmd_y+row) and advance.
    - Raster order: col increments fastest; at col==w-1, col wraps to 0 and row increments.
    - After pixel (w-1, h-1), go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Handshake: transfer occurs when cmd_valid && cmd_ready. cmd_ready is 0 in DRAW and DONE; cmd_valid in those states is ignored. The issuer holds the command until accepted.
- Arithmetic:
  - xout = cmd_x + col, truncated to X_W bits.
  - yout = cmd_y + row, truncated to Y_W bits.
  - The counters have the same widths as cmd_w and cmd_h. w=255 and h=127 are legal.
- Plot rules:
  - plot=1 only in DRAW, and only when the pixel is enabled.
  - With cmd_outline=1, a pixel is enabled only when col==0, col==w-1, row==0 or row==h-1.
  - Every pixel position still costs one cycle, so cycle count does not depend on mode.
- busy=1 in DRAW and DONE.
- colourout holds the latched colour in DRAW; it is 0 elsewhere.
- Reset (including mid-draw): on the next edge, state=IDLE, counters=0, and xout, yout, colourout, plot, busy, done = 0, with cmd_ready=1. The partially drawn rectangle is abandoned.

## Timing
- Accept on edge N. The first pixel appears on the registered outputs in cycle N+1. Pixel k (0-based) appears in cycle N+1+k.
- The last pixel is in cycle N+w*h. done is high in cycle N+w*h+1. cmd_ready returns in cycle N+w*h+2.
- For an empty command (w==0 or h==0): done in cycle N+1, no plot.
- All adapter-facing outputs are registered; there are no combinational paths from cmd_* to xout, yout, colourout or plot.
- Back-to-back commands: minimum spacing is w*h+2 cycles.

## Configuration
- RECT_PLOTTER_CLIP_EN defined:
  - A pixel with xout>=160 or yout>=120, or whose coordinate addition overflowed, has plot forced to 0.
  - Its cycle is still spent.
- RECT_PLOTTER_CLIP_EN undefined: no clipping. Coordinates wrap modulo 2^X_W and 2^Y_W, and plot follows the fill/outline rule only.

## Structure
- Shared package draw_pkg holds:
  - SCREEN_W=160, SCREEN_H=120
  - X_W, Y_W, C_W defaults
  - colour constants (BLACK=3'b000, RED=3'b100, WHITE=3'b111, ...)
  - state encoding IDLE/DRAW/DONE
- Sub-module raster_counter holds the col/row counter pair. It has:
  - inputs: start, step, w, h
  - outputs: col, row, last, is_edge

## Test plan
- Solid fill: cmd (x=10, y=5, w=3, h=2, colour=3'b100) -> six plots in order (10,5) (11,5) (12,5) (10,6) (11,6) (12,6) on cycles N+1..N+6, done at N+7, cmd_ready at N+8.
- Outline: (x=0, y=0, w=4, h=3, outline=1) -> 12 cycles in DRAW, plot=1 on 10 pixels, plot=0 at (1,1) and (2,1).
- Empty: w=0, h=5 -> no plot, done at N+1.
- Clipping with RECT_PLOTTER_CLIP_EN: (x=158, y=118, w=3, h=3) -> plot only at (158,118) (159,118) (158,119) (159,119), done at N+10. Without the macro: 9 plots with x=160 present.
- Busy/backpressure: assert a second cmd_valid during DRAW -> not accepted; it is accepted on the first IDLE cycle and its fields are latched then.
- Reset mid-draw: assert reset at pixel 3 of a 4x4 rectangle -> next cycle plot=0, busy=0, done=0, xout=yout=0, cmd_ready=1, and no done pulse afterwards.
